// File: rtl/tlul_timer_dev.sv
// rtl/tlul_timer_dev.sv - TL-UL device with prescaled compare/reload timer
package tlul_pkg;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [7:0]  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module tlul_timer_dev #(
  parameter int unsigned PrescaleW    = 16,
  parameter logic [31:0] ResetCompare = 32'hFFFF_FFFF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  tlul_pkg::tl_h2d_t tl_i,
  output tlul_pkg::tl_d2h_t tl_o,
  output logic              irq_o
);
  localparam logic [2:0] OpPutFull    = 3'd0;
  localparam logic [2:0] OpPutPartial = 3'd1;
  localparam logic [2:0] OpGet        = 3'd4;

  logic [2:0]           ctrl_q;       // [0] enable, [1] reload, [2] irq_en
  logic [PrescaleW-1:0] prescale_q;
  logic [PrescaleW-1:0] pre_cnt_q;
  logic [31:0]          count_q;
  logic [31:0]          compare_q;
  logic                 match_q;

  logic        rsp_valid;
  logic [2:0]  rsp_opcode;
  logic [1:0]  rsp_size;
  logic [7:0]  rsp_source;
  logic [31:0] rsp_data;
  logic        rsp_error;

  logic        a_ready, accept, is_get, is_put, hit, err;
  logic [9:0]  offset;
  logic [31:0] reg_rdata, wval;
  logic        wr_en, tick, match_set;
  logic        unused_bits;

  assign unused_bits = ^{tl_i.a_param, tl_i.a_address[31:10]};

  assign a_ready = ~rsp_valid | tl_i.d_ready;
  assign accept  = tl_i.a_valid & a_ready;
  assign offset  = tl_i.a_address[9:0];
  assign is_get  = (tl_i.a_opcode == OpGet);
  assign is_put  = (tl_i.a_opcode == OpPutFull) | (tl_i.a_opcode == OpPutPartial);

  // Register read mux; also flags whether the offset is mapped
  always_comb begin
    reg_rdata = '0;
    hit       = 1'b1;
    case (offset)
      10'h000: reg_rdata = {29'b0, ctrl_q};
      10'h004: reg_rdata = 32'(prescale_q);
      10'h008: reg_rdata = count_q;
      10'h00C: reg_rdata = compare_q;
      10'h010: reg_rdata = {31'b0, match_q};
      default: hit = 1'b0;
    endcase
  end

  assign err = ~(is_get | is_put) | (tl_i.a_address[1:0] != 2'b00) | (tl_i.a_size == 2'd3)
             | ~hit | ((tl_i.a_opcode == OpPutFull) & (tl_i.a_mask != 4'hF));

  // Byte-lane merge of bus data into the current register value
  always_comb begin
    wval = reg_rdata;
    for (int b = 0; b < 4; b++) begin
      if (tl_i.a_mask[b]) wval[8*b +: 8] = tl_i.a_data[8*b +: 8];
    end
  end

  assign wr_en     = accept & ~err & is_put;
  assign tick      = ctrl_q[0] & (pre_cnt_q == prescale_q);
  assign match_set = tick & (count_q == compare_q);

  // Configuration registers written from the bus
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      compare_q  <= ResetCompare;
    end else if (wr_en) begin
      if (offset == 10'h000) ctrl_q     <= wval[2:0];
      if (offset == 10'h004) prescale_q <= wval[PrescaleW-1:0];
      if (offset == 10'h00C) compare_q  <= wval;
    end
  end

  // Prescaler, counter and match flag; bus write to COUNT wins over a tick
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_cnt_q <= '0;
      count_q   <= '0;
      match_q   <= 1'b0;
    end else begin
      if (wr_en && (offset == 10'h000 || offset == 10'h004)) pre_cnt_q <= '0;
      else if (tick)                                          pre_cnt_q <= '0;
      else if (ctrl_q[0])                                     pre_cnt_q <= pre_cnt_q + PrescaleW'(1);

      if (wr_en && offset == 10'h008)  count_q <= wval;
      else if (match_set && ctrl_q[1]) count_q <= '0;
      else if (tick)                   count_q <= count_q + 32'd1;

      if (match_set)                                                   match_q <= 1'b1;
      else if (wr_en && offset == 10'h010 && tl_i.a_mask[0] && tl_i.a_data[0]) match_q <= 1'b0;
    end
  end

  // One-entry response buffer, loaded on accept and drained by d_ready
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid  <= 1'b0;
      rsp_opcode <= '0;
      rsp_size   <= '0;
      rsp_source <= '0;
      rsp_data   <= '0;
      rsp_error  <= 1'b0;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_opcode <= is_get ? 3'd1 : 3'd0;
      rsp_size   <= tl_i.a_size;
      rsp_source <= tl_i.a_source;
      rsp_data   <= (is_get && !err) ? reg_rdata : 32'd0;
      rsp_error  <= err;
    end else if (tl_i.d_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

  // D-channel drive; unused response fields stay zero
  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = rsp_valid;
    tl_o.d_opcode = rsp_opcode;
    tl_o.d_size   = rsp_size;
    tl_o.d_source = rsp_source;
    tl_o.d_data   = rsp_data;
    tl_o.d_error  = rsp_error;
    tl_o.a_ready  = a_ready;
  end

  assign irq_o = match_q & ctrl_q[2];
endmodule

// File: tb/tb_tlul_timer_dev.sv
// tb/tb_tlul_timer_dev.sv - directed self-checking bench for tlul_timer_dev
module tb_tlul_timer_dev;
  logic clk = 1'b0;
  logic rst = 1'b1;
  tlul_pkg::tl_h2d_t tl_i;
  tlul_pkg::tl_d2h_t tl_o;
  tlul_pkg::tl_d2h_t rsp;
  logic irq;
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  tlul_timer_dev dut (
    .clk_i(clk),
    .rst_i(rst),
    .tl_i (tl_i),
    .tl_o (tl_o),
    .irq_o(irq)
  );

  // Issue one request with d_ready high; rsp holds the D beat seen one cycle after accept
  task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] mask, input logic [1:0] size, input logic [7:0] src);
    int w;
    @(negedge clk);
    tl_i.a_valid = 1'b1; tl_i.a_opcode = op; tl_i.a_address = addr; tl_i.a_data = data;
    tl_i.a_mask = mask; tl_i.a_size = size; tl_i.a_source = src; tl_i.d_ready = 1'b1;
    w = 0;
    while (!tl_o.a_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) begin
      total++;
      $display("FAIL send_timeout a_ready=%0b required 1", tl_o.a_ready);
    end
    @(posedge clk);
    @(negedge clk);
    tl_i.a_valid = 1'b0;
    rsp = tl_o;
  endtask

  task automatic test_reset();
    total++; if (tl_o.d_valid !== 1'b0) $display("FAIL rst_d_valid got %0b exp 0", tl_o.d_valid); else passed++;
    total++; if (tl_o.a_ready !== 1'b1) $display("FAIL rst_a_ready got %0b exp 1", tl_o.a_ready); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL rst_irq got %0b exp 0", irq); else passed++;
    total++; if (tl_o.d_data !== 32'd0 || tl_o.d_error !== 1'b0 || tl_o.d_source !== 8'd0)
      $display("FAIL rst_d_fields got data=%h err=%0b src=%0d exp 0", tl_o.d_data, tl_o.d_error, tl_o.d_source);
    else passed++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_get_compare();
    send(3'd4, 32'hC000_000C, 32'd0, 4'hF, 2'd2, 8'd5);
    total++; if (rsp.d_valid !== 1'b1) $display("FAIL get_valid got %0b exp 1", rsp.d_valid); else passed++;
    total++; if (rsp.d_opcode !== 3'd1) $display("FAIL get_opcode got %0d exp 1", rsp.d_opcode); else passed++;
    total++; if (rsp.d_source !== 8'd5 || rsp.d_size !== 2'd2) $display("FAIL get_echo got src=%0d size=%0d exp 5/2", rsp.d_source, rsp.d_size); else passed++;
    total++; if (rsp.d_data !== 32'hFFFF_FFFF) $display("FAIL get_data got %h exp ffffffff", rsp.d_data); else passed++;
    total++; if (rsp.d_error !== 1'b0) $display("FAIL get_error got %0b exp 0", rsp.d_error); else passed++;
  endtask

  task automatic test_partial();
    send(3'd1, 32'h0000_0008, 32'hAABB_CCDD, 4'b0101, 2'd2, 8'd1);
    total++; if (rsp.d_opcode !== 3'd0 || rsp.d_error !== 1'b0) $display("FAIL put_ack got op=%0d err=%0b exp 0/0", rsp.d_opcode, rsp.d_error); else passed++;
    send(3'd4, 32'h0000_0008, 32'd0, 4'hF, 2'd2, 8'd2);
    total++; if (rsp.d_data !== 32'h00BB_00DD) $display("FAIL partial_data got %h exp 00bb00dd", rsp.d_data); else passed++;
  endtask

  task automatic test_errors();
    send(3'd4, 32'h0000_0014, 32'd0, 4'hF, 2'd2, 8'd3);
    total++; if (rsp.d_error !== 1'b1 || rsp.d_data !== 32'd0) $display("FAIL err_unmapped got err=%0b data=%h exp 1/0", rsp.d_error, rsp.d_data); else passed++;
    send(3'd4, 32'h0000_0002, 32'd0, 4'hF, 2'd2, 8'd3);
    total++; if (rsp.d_error !== 1'b1 || rsp.d_data !== 32'd0) $display("FAIL err_misaligned got err=%0b data=%h exp 1/0", rsp.d_error, rsp.d_data); else passed++;
    send(3'd3, 32'h0000_0008, 32'd0, 4'hF, 2'd2, 8'd3);
    total++; if (rsp.d_error !== 1'b1 || rsp.d_data !== 32'd0) $display("FAIL err_opcode got err=%0b data=%h exp 1/0", rsp.d_error, rsp.d_data); else passed++;
    send(3'd0, 32'h0000_000C, 32'd0, 4'h3, 2'd2, 8'd3);
    total++; if (rsp.d_error !== 1'b1) $display("FAIL err_putfull_mask got err=%0b exp 1", rsp.d_error); else passed++;
    send(3'd4, 32'h0000_0008, 32'd0, 4'hF, 2'd3, 8'd3);
    total++; if (rsp.d_error !== 1'b1) $display("FAIL err_size got err=%0b exp 1", rsp.d_error); else passed++;
    send(3'd4, 32'h0000_000C, 32'd0, 4'hF, 2'd2, 8'd3);
    total++; if (rsp.d_data !== 32'hFFFF_FFFF) $display("FAIL err_compare_kept got %h exp ffffffff", rsp.d_data); else passed++;
    send(3'd4, 32'h0000_0008, 32'd0, 4'hF, 2'd2, 8'd3);
    total++; if (rsp.d_data !== 32'h00BB_00DD) $display("FAIL err_count_kept got %h exp 00bb00dd", rsp.d_data); else passed++;
  endtask

  task automatic test_back_to_back();
    tlul_pkg::tl_d2h_t first;
    @(negedge clk);
    tl_i.d_ready = 1'b0; tl_i.a_valid = 1'b1; tl_i.a_opcode = 3'd4; tl_i.a_address = 32'h0C;
    tl_i.a_mask = 4'hF; tl_i.a_size = 2'd2; tl_i.a_source = 8'd1;
    @(posedge clk); @(negedge clk);
    first = tl_o;
    total++; if (tl_o.d_valid !== 1'b1 || tl_o.a_ready !== 1'b0) $display("FAIL hold_first got v=%0b rdy=%0b exp 1/0", tl_o.d_valid, tl_o.a_ready); else passed++;
    tl_i.a_address = 32'h08; tl_i.a_source = 8'd2;
    @(posedge clk); @(negedge clk);
    total++; if (tl_o.d_source !== 8'd1 || tl_o.d_data !== 32'hFFFF_FFFF || tl_o.d_valid !== 1'b1)
      $display("FAIL hold_stable got src=%0d data=%h v=%0b exp 1/ffffffff/1", tl_o.d_source, tl_o.d_data, tl_o.d_valid);
    else passed++;
    total++; if (tl_o.a_ready !== 1'b0) $display("FAIL hold_a_ready got %0b exp 0", tl_o.a_ready); else passed++;
    tl_i.d_ready = 1'b1;
    #1;
    total++; if (tl_o.a_ready !== 1'b1) $display("FAIL release_a_ready got %0b exp 1", tl_o.a_ready); else passed++;
    @(posedge clk); @(negedge clk);
    tl_i.a_valid = 1'b0;
    total++; if (tl_o.d_valid !== 1'b1 || tl_o.d_source !== 8'd2 || tl_o.d_data !== 32'h00BB_00DD)
      $display("FAIL second_rsp got v=%0b src=%0d data=%h exp 1/2/00bb00dd", tl_o.d_valid, tl_o.d_source, tl_o.d_data);
    else passed++;
    @(negedge clk);
    total++; if (tl_o.d_valid !== 1'b0) $display("FAIL drain got %0b exp 0", tl_o.d_valid); else passed++;
  endtask

  task automatic test_counter_match();
    send(3'd0, 32'h04, 32'd3, 4'hF, 2'd2, 8'd0);
    send(3'd0, 32'h0C, 32'd2, 4'hF, 2'd2, 8'd0);
    send(3'd0, 32'h08, 32'd0, 4'hF, 2'd2, 8'd0);
    send(3'd0, 32'h00, 32'd7, 4'hF, 2'd2, 8'd0);
    repeat (11) @(negedge clk);
    total++; if (irq !== 1'b0) $display("FAIL irq_early got %0b exp 0", irq); else passed++;
    @(negedge clk);
    total++; if (irq !== 1'b1) $display("FAIL irq_12th got %0b exp 1", irq); else passed++;
    send(3'd4, 32'h08, 32'd0, 4'hF, 2'd2, 8'd0);
    total++; if (rsp.d_data !== 32'd0) $display("FAIL reload_count got %h exp 0", rsp.d_data); else passed++;
    send(3'd0, 32'h10, 32'd1, 4'hF, 2'd2, 8'd0);
    total++; if (irq !== 1'b0) $display("FAIL irq_w1c got %0b exp 0", irq); else passed++;
    send(3'd0, 32'h00, 32'd0, 4'hF, 2'd2, 8'd0);
  endtask

  task automatic test_wrap_and_reset();
    send(3'd0, 32'h08, 32'hFFFF_FFFF, 4'hF, 2'd2, 8'd0);
    send(3'd0, 32'h0C, 32'd5, 4'hF, 2'd2, 8'd0);
    send(3'd0, 32'h04, 32'd0, 4'hF, 2'd2, 8'd0);
    send(3'd0, 32'h00, 32'd1, 4'hF, 2'd2, 8'd0);
    send(3'd4, 32'h08, 32'd0, 4'hF, 2'd2, 8'd0);
    total++; if (rsp.d_data !== 32'd0) $display("FAIL wrap_count got %h exp 0", rsp.d_data); else passed++;
    send(3'd4, 32'h10, 32'd0, 4'hF, 2'd2, 8'd0);
    total++; if (rsp.d_data !== 32'd0) $display("FAIL wrap_no_match got %h exp 0", rsp.d_data); else passed++;
    @(negedge clk);
    tl_i.d_ready = 1'b0; tl_i.a_valid = 1'b1; tl_i.a_opcode = 3'd4; tl_i.a_address = 32'h0C; tl_i.a_source = 8'd9;
    @(posedge clk); @(negedge clk);
    tl_i.a_valid = 1'b0;
    total++; if (tl_o.d_valid !== 1'b1) $display("FAIL pend_before_rst got %0b exp 1", tl_o.d_valid); else passed++;
    rst = 1'b1;
    #1;
    total++; if (tl_o.d_valid !== 1'b0) $display("FAIL rst_drop got %0b exp 0", tl_o.d_valid); else passed++;
    @(negedge clk); rst = 1'b0; tl_i.d_ready = 1'b1;
    begin
      int stale = 0;
      repeat (4) begin
        @(negedge clk);
        if (tl_o.d_valid !== 1'b0) stale++;
      end
      total++; if (stale != 0) $display("FAIL stale_rsp got %0d beats exp 0", stale); else passed++;
    end
    send(3'd4, 32'h0C, 32'd0, 4'hF, 2'd2, 8'd0);
    total++; if (rsp.d_data !== 32'hFFFF_FFFF) $display("FAIL post_rst_compare got %h exp ffffffff", rsp.d_data); else passed++;
  endtask

  initial begin
    tl_i = '0;
    tl_i.d_ready = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_get_compare();
    test_partial();
    test_errors();
    test_back_to_back();
    test_counter_match();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
